// File: rtl/add.sv
// -----------------------------------------------------------------------------
// add -- registered two-operand integer adder with valid/ready handshakes.
//
// Purpose
//   Functional unit for HLS-generated datapaths. Takes one operand pair per
//   cycle. One cycle later it returns the sum together with a carry-out flag
//   and an overflow flag. The output side honours backpressure, so the unit
//   can sit between stalling pipeline stages without losing or duplicating
//   results.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   SIGNED  1: two's-complement overflow rule; 0: unsigned (ovf mirrors cout)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-low (0 = reset)
//   in_valid   in   1      operand pair present
//   in_ready   out  1      unit can accept an operand pair this cycle
//   in0        in   WIDTH  operand A
//   in1        in   WIDTH  operand B
//   cin        in   1      carry-in, LSB weight 1
//   out_valid  out  1      result register holds an unconsumed result
//   out_ready  in   1      consumer takes the result this cycle
//   out        out  WIDTH  sum (wrapped, or clamped when saturation is built in)
//   cout       out  1      carry out of the MSB
//   ovf        out  1      overflow flag
//
// Build options
//   ADD_SATURATE_EN  When defined, a result whose ovf would be 1 is clamped:
//                    signed  -> 0111..1 (positive) / 1000..0 (negative)
//                    unsigned-> all ones
//                    cout and ovf still report the unclamped condition.
//                    When undefined, out always wraps and no clamp logic exists.
// -----------------------------------------------------------------------------
module add #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  // Full-precision sum: one extra bit holds the carry out of the MSB.
  function automatic logic [WIDTH:0] full_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             c
  );
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  // Overflow: signed mode flags a sign flip when both operands share a sign;
  // unsigned mode treats a carry out of the MSB as the overflow.
  function automatic logic ovf_flag(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] s,
    input logic             carry
  );
    logic flag;
    if (SIGNED) begin
      flag = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      flag = carry;
    end
    return flag;
  endfunction

`ifdef ADD_SATURATE_EN
  // Clamp value for an overflowing result. In signed mode, both operands share
  // a sign whenever ovf is set, so operand A's sign picks the rail.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [WIDTH-1:0] v;
    if (SIGNED) begin
      if (neg) begin
        v = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        v = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      v = {WIDTH{1'b1}};
    end
    return v;
  endfunction
`endif

  logic [WIDTH:0]   full_s;
  logic [WIDTH-1:0] res_s;
  logic             cout_s;
  logic             ovf_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;

  logic [WIDTH-1:0] out_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  // Space exists when the result register is empty or is being consumed now.
  // This is what lets a drain and an accept share one cycle with no bubble.
  assign in_ready_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign drain_s    = out_valid_r && out_ready;

  // Next-result datapath: sum, flags and the optional clamp.
  always_comb begin
    full_s = full_sum(in0, in1, cin);
    cout_s = full_s[WIDTH];
    ovf_s  = ovf_flag(in0, in1, full_s[WIDTH-1:0], cout_s);
`ifdef ADD_SATURATE_EN
    if (ovf_s) begin
      res_s = sat_value(in0[WIDTH-1]);
    end else begin
      res_s = full_s[WIDTH-1:0];
    end
`else
    res_s = full_s[WIDTH-1:0];
`endif
  end

  // Result register. The data fields load only on accept, so idle or garbage
  // operands never reach the outputs. A drain clears only the valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        out_r       <= res_s;
        cout_r      <= cout_s;
        ovf_r       <= ovf_s;
        out_valid_r <= 1'b1;
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_add.sv
// -----------------------------------------------------------------------------
// tb_add -- scoreboard bench for add (WIDTH=8).
// A signed and an unsigned instance share every input. The driver pushes the
// reference result for each accepted pair into a per-instance queue. The
// monitor pops and compares whenever an instance hands over a result.
// -----------------------------------------------------------------------------
module tb_add;

  typedef struct {
    logic [7:0] o;
    logic       c;
    logic       v;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       cin;
  logic       out_ready;

  logic       in_ready_s, out_valid_s, cout_s, ovf_s;
  logic [7:0] out_s;
  logic       in_ready_u, out_valid_u, cout_u, ovf_u;
  logic [7:0] out_u;

  int   total = 0;
  int   bad   = 0;
  bit   rand_ready = 1'b0;
  res_t qs[$];
  res_t qu[$];
  res_t es;
  res_t eu;

  add #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in0(in0), .in1(in1), .cin(cin), .out_valid(out_valid_s),
    .out_ready(out_ready), .out(out_s), .cout(cout_s), .ovf(ovf_s)
  );

  add #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in0(in0), .in1(in1), .cin(cin), .out_valid(out_valid_u),
    .out_ready(out_ready), .out(out_u), .cout(cout_u), .ovf(ovf_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input int a, input int b, input int c, input bit sgn);
    res_t r;
    int t;
    int sa;
    int sb;
    int st;
    t  = a + b + c;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    st = sa + sb + c;
    r.o = 8'(t % 256);
    r.c = (t >= 256);
    r.v = sgn ? ((st > 127) || (st < -128)) : (t >= 256);
`ifdef ADD_SATURATE_EN
    if (r.v) begin
      if (sgn) r.o = (st > 127) ? 8'h7F : 8'h80;
      else     r.o = 8'hFF;
    end
`endif
    return r;
  endfunction

  // Present one pair and hold it until accepted; the caller is at posedge+1.
  // The task returns at posedge+1 just after the accepting edge.
  task automatic send_one(input int a, input int b, input int c, output int waits);
    in0 = 8'(a);
    in1 = 8'(b);
    cin = c[0];
    in_valid = 1'b1;
    waits = 0;
    for (int k = 0; k < 50; k++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready_s) begin
        qs.push_back(model(a, b, c, 1'b1));
        qu.push_back(model(a, b, c, 1'b0));
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      waits++;
    end
    total++;
    bad++;
    $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
  endtask

  // Monitor: a result is consumed at the next rising edge whenever valid and
  // ready are both high; sample it at the falling edge.
  always @(negedge clk) begin
    if (out_valid_s && out_ready) begin
      if (qs.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_s_extra: got result %0h expected none", out_s);
      end else begin
        es = qs.pop_front();
        check("mon_s_out",  32'(out_s),  32'(es.o));
        check("mon_s_cout", 32'(cout_s), 32'(es.c));
        check("mon_s_ovf",  32'(ovf_s),  32'(es.v));
      end
    end
    if (out_valid_u && out_ready) begin
      if (qu.size() == 0) begin
        total++; bad++;
        $display("FAIL mon_u_extra: got result %0h expected none", out_u);
      end else begin
        eu = qu.pop_front();
        check("mon_u_out",  32'(out_u),  32'(eu.o));
        check("mon_u_cout", 32'(cout_u), 32'(eu.c));
        check("mon_u_ovf",  32'(ovf_u),  32'(eu.v));
      end
    end
  end

  initial begin
    int w;
    int a;
    int b;
    rst = 1'b0; in_valid = 1'b0; in0 = 8'h00; in1 = 8'h00; cin = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_valid", 32'(out_valid_s), 32'd0);
    check("reset_out",   32'(out_s),       32'd0);
    check("reset_ready", 32'(in_ready_s),  32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, consumer always ready.
    out_ready = 1'b1;
    send_one(8'h12, 8'h34, 1, w); in_valid = 1'b0;
    check("basic_valid", 32'(out_valid_s), 32'd1);
    check("basic_out",   32'(out_s),  32'h47);
    check("basic_cout",  32'(cout_s), 32'd0);
    check("basic_ovf",   32'(ovf_s),  32'd0);

    send_one(8'h7F, 8'h01, 0, w); in_valid = 1'b0;
`ifdef ADD_SATURATE_EN
    check("sovf_out", 32'(out_s), 32'h7F);
`else
    check("sovf_out", 32'(out_s), 32'h80);
`endif
    check("sovf_cout", 32'(cout_s), 32'd0);
    check("sovf_ovf",  32'(ovf_s),  32'd1);
    check("sovf_u_out", 32'(out_u), 32'h80);
    check("sovf_u_ovf", 32'(ovf_u), 32'd0);

    send_one(8'hFF, 8'h02, 0, w); in_valid = 1'b0;
`ifdef ADD_SATURATE_EN
    check("ucarry_out", 32'(out_u), 32'hFF);
`else
    check("ucarry_out", 32'(out_u), 32'h01);
`endif
    check("ucarry_cout", 32'(cout_u), 32'd1);
    check("ucarry_ovf",  32'(ovf_u),  32'd1);
    check("ucarry_s_out", 32'(out_s), 32'h01);
    check("ucarry_s_ovf", 32'(ovf_s), 32'd0);
    @(posedge clk); #1;

    // Backpressure: three stalled cycles, then drain and accept together.
    out_ready = 1'b0;
    send_one(8'h55, 8'h22, 0, w);
    in0 = 8'h10; in1 = 8'h20; cin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready_s),  32'd0);
      check("bp_out_valid", 32'(out_valid_s), 32'd1);
      check("bp_out",       32'(out_s),       32'h77);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_one(8'h10, 8'h20, 1, w);
    in_valid = 1'b0;
    check("bp_no_wait", 32'(w), 32'd0);
    check("bp_replace_valid", 32'(out_valid_s), 32'd1);
    check("bp_replace_out",   32'(out_s),       32'h31);
    @(posedge clk); #1;

    // Streaming: 16 back-to-back pairs, one result per cycle.
    for (int i = 0; i < 16; i++) begin
      send_one(i, 2 * i, 0, w);
      check("stream_wait",  32'(w),           32'd0);
      check("stream_valid", 32'(out_valid_s), 32'd1);
      check("stream_out",   32'(out_s),       32'((3 * i) % 256));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic with random gaps and random consumer stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      send_one(a, b, int'($urandom_range(0, 1)), w);
      in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_q_s", 32'(qs.size()), 32'd0);
    check("drain_q_u", 32'(qu.size()), 32'd0);

    // Mid-stream reset: a held result is discarded without a clock edge.
    out_ready = 1'b0;
    send_one(8'h12, 8'h34, 1, w);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid_s), 32'd0);
    check("rst_mid_out",   32'(out_s),       32'd0);
    check("rst_mid_cout",  32'(cout_u),      32'd0);
    check("rst_mid_ovf",   32'(ovf_s),       32'd0);
    check("rst_mid_u_out", 32'(out_u),       32'd0);
    qs.delete();
    qu.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_one(8'hF0, 8'h0F, 1, w);
    in_valid = 1'b0;
    check("post_rst_out",  32'(out_s),  32'h00);
    check("post_rst_cout", 32'(cout_s), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("final_q_s", 32'(qs.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
